// File: rtl/alu_result_serializer.sv
// Captures ALU result words into a small FIFO and streams them out LSB byte first on a valid/ready port.
// Define ALU_SER_CHKSUM_EN to append an XOR checksum byte after each word.
module alu_result_serializer #(
   parameter int OUT_WIDTH  = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int DEPTH      = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [OUT_WIDTH-1:0]  ALU_OUT,
   input  logic                  OUT_VALID,
   output logic [BYTE_WIDTH-1:0] TX_DATA,
   output logic                  TX_VALID,
   input  logic                  TX_READY,
   output logic                  BUSY,
   output logic                  OVERFLOW,
   input  logic                  CLR_OVF
);

   localparam int NBYTES = OUT_WIDTH / BYTE_WIDTH;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef ALU_SER_CHKSUM_EN
   typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
`else
   typedef enum logic {IDLE, SEND} state_t;
`endif

   state_t                 state, state_nx;
   logic [OUT_WIDTH-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0]       count;
   logic [OUT_WIDTH-1:0]   shift_reg, shift_nx;
   logic [IDX_W-1:0]       idx, idx_nx;
   logic                   pop, push, drop, full;

`ifdef ALU_SER_CHKSUM_EN
   logic [BYTE_WIDTH-1:0]  chk_reg, chk_nx, head_xor;

   always_comb begin
      head_xor = '0;
      for (int unsigned i = 0; i < NBYTES; i++)
         head_xor = head_xor ^ mem[rd_ptr][i*BYTE_WIDTH +: BYTE_WIDTH];
   end
`endif

   assign full = (count == CNT_W'(DEPTH));
   // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
   assign push = OUT_VALID && (!full || pop);
   assign drop = OUT_VALID && full && !pop;
   assign BUSY = (state != IDLE) || (count != '0);

   always_comb begin
      state_nx = state;
      shift_nx = shift_reg;
      idx_nx   = idx;
      pop      = 1'b0;
      TX_VALID = 1'b0;
      TX_DATA  = '0;
`ifdef ALU_SER_CHKSUM_EN
      chk_nx   = chk_reg;
`endif
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop      = 1'b1;
               shift_nx = mem[rd_ptr];
               idx_nx   = '0;
               state_nx = SEND;
`ifdef ALU_SER_CHKSUM_EN
               chk_nx   = head_xor;
`endif
            end
         end
         SEND: begin
            TX_VALID = 1'b1;
            TX_DATA  = shift_reg[BYTE_WIDTH-1:0];
            if (TX_READY) begin
               shift_nx = shift_reg >> BYTE_WIDTH;
               idx_nx   = idx + IDX_W'(1);
               if (idx == IDX_W'(NBYTES - 1)) begin
`ifdef ALU_SER_CHKSUM_EN
                  state_nx = CHK;
`else
                  state_nx = IDLE;
`endif
               end
            end
         end
`ifdef ALU_SER_CHKSUM_EN
         CHK: begin
            TX_VALID = 1'b1;
            TX_DATA  = chk_reg;
            if (TX_READY) state_nx = IDLE;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= ALU_OUT;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         shift_reg <= '0;
         idx       <= '0;
         OVERFLOW  <= 1'b0;
`ifdef ALU_SER_CHKSUM_EN
         chk_reg   <= '0;
`endif
      end else begin
         state     <= state_nx;
         shift_reg <= shift_nx;
         idx       <= idx_nx;
`ifdef ALU_SER_CHKSUM_EN
         chk_reg   <= chk_nx;
`endif
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
         if (drop)         OVERFLOW <= 1'b1;
         else if (CLR_OVF) OVERFLOW <= 1'b0;
      end
   end

endmodule
